// File: rtl/vga_ctrl_sequencer.sv
// Control plane ahead of the VGA datapath: debounces buttons/switches, edits pending
// mode/box/colour registers and commits them to the outputs only at a frame boundary.
module vga_ctrl_sequencer #(
    parameter int DEB_CYCLES = 500000,
    parameter int STEP       = 8,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int BOX        = 32
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       func_switch,
    input  logic       East,
    input  logic       West,
    input  logic       North,
    input  logic       South,
    input  logic       SW0,
    input  logic       SW1,
    input  logic       SW2,
    input  logic       SW3,
    input  logic       frame_start,
    output logic [1:0] mode,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic [2:0] colour,
    output logic       cfg_valid,
    output logic       o_dbg_dirty
);

    localparam int             NIN      = 9;
    localparam int             CW       = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [10:0]    STEP_W   = 11'(STEP);
    localparam logic [10:0]    X_MAX    = 11'(H_ACTIVE - BOX);
    localparam logic [10:0]    Y_MAX    = 11'(V_ACTIVE - BOX);
    localparam logic [9:0]     X_RST    = 10'((H_ACTIVE - BOX) / 2);
    localparam logic [9:0]     Y_RST    = 10'((V_ACTIVE - BOX) / 2);

    typedef enum logic {CLEAN = 1'b0, DIRTY = 1'b1} state_t;

    // Bit map: 0 func, 1 East, 2 West, 3 North, 4 South, 5 SW0, 6 SW1, 7 SW2, 8 SW3.
    logic [NIN-1:0] w_raw;
    logic [NIN-1:0] r_sync1;
    logic [NIN-1:0] r_sync2;
    logic [NIN-1:0] r_deb;
    logic [CW-1:0]  r_cnt [NIN];
    logic [NIN-1:0] w_flip;
    logic [4:0]     r_press;
    logic           r_sw_evt;

    state_t         r_state;
    logic [1:0]     r_pend_mode;
    logic [9:0]     r_pend_x;
    logic [9:0]     r_pend_y;
    logic [2:0]     r_pend_col;

    logic [1:0]     w_mode_n;
    logic [9:0]     w_x_n;
    logic [9:0]     w_y_n;
    logic [2:0]     w_col_n;
    logic           w_box_en;
    logic           w_change;
    logic           w_commit;
    logic [10:0]    w_x_inc;
    logic [10:0]    w_x_dec;
    logic [10:0]    w_y_inc;
    logic [10:0]    w_y_dec;

    assign w_raw = {SW3, SW2, SW1, SW0, South, North, West, East, func_switch};

    always_comb begin
        w_flip = '0;
        for (int k = 0; k < NIN; k++) begin
            w_flip[k] = (r_sync2[k] != r_deb[k]) && (r_cnt[k] == CNT_LAST);
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_deb    <= '0;
            r_press  <= '0;
            r_sw_evt <= 1'b0;
            for (int k = 0; k < NIN; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_sync1  <= w_raw;
            r_sync2  <= r_sync1;
            r_press  <= w_flip[4:0] & r_sync2[4:0];
            r_sw_evt <= |w_flip[7:5];
            for (int k = 0; k < NIN; k++) begin
                if (r_sync2[k] == r_deb[k]) begin
                    r_cnt[k] <= '0;
                end else if (w_flip[k]) begin
                    r_deb[k] <= r_sync2[k];
                    r_cnt[k] <= '0;
                end else begin
                    r_cnt[k] <= r_cnt[k] + CW'(1);
                end
            end
        end
    end

    assign w_x_inc = {1'b0, r_pend_x} + STEP_W;
    assign w_x_dec = {1'b0, r_pend_x} - STEP_W;
    assign w_y_inc = {1'b0, r_pend_y} + STEP_W;
    assign w_y_dec = {1'b0, r_pend_y} - STEP_W;
    assign w_box_en = (r_pend_mode == 2'd1);

    // Opposing presses in the same cycle cancel; moves clamp to the visible area.
    always_comb begin
        w_mode_n = r_pend_mode + {1'b0, r_press[0]};
        w_x_n    = r_pend_x;
        w_y_n    = r_pend_y;
        w_col_n  = r_sw_evt ? r_deb[7:5] : r_pend_col;
        if (w_box_en && r_press[1] && !r_press[2]) begin
            w_x_n = (w_x_inc > X_MAX) ? 10'(X_MAX) : w_x_inc[9:0];
        end else if (w_box_en && r_press[2] && !r_press[1]) begin
            w_x_n = ({1'b0, r_pend_x} >= STEP_W) ? w_x_dec[9:0] : 10'd0;
        end
        if (w_box_en && r_press[4] && !r_press[3]) begin
            w_y_n = (w_y_inc > Y_MAX) ? 10'(Y_MAX) : w_y_inc[9:0];
        end else if (w_box_en && r_press[3] && !r_press[4]) begin
            w_y_n = ({1'b0, r_pend_y} >= STEP_W) ? w_y_dec[9:0] : 10'd0;
        end
        w_change = (w_mode_n != r_pend_mode) || (w_x_n != r_pend_x) ||
                   (w_y_n != r_pend_y) || (w_col_n != r_pend_col);
    end

    assign w_commit    = (r_state == DIRTY) && frame_start && !r_deb[8];
    assign o_dbg_dirty = (r_state == DIRTY);

    // A commit copies the pre-update pending values; a change in the same cycle re-dirties.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state     <= CLEAN;
            r_pend_mode <= 2'd0;
            r_pend_x    <= X_RST;
            r_pend_y    <= Y_RST;
            r_pend_col  <= 3'b111;
            mode        <= 2'd0;
            box_x       <= X_RST;
            box_y       <= Y_RST;
            colour      <= 3'b111;
            cfg_valid   <= 1'b0;
        end else begin
            r_pend_mode <= w_mode_n;
            r_pend_x    <= w_x_n;
            r_pend_y    <= w_y_n;
            r_pend_col  <= w_col_n;
            cfg_valid   <= w_commit;
            if (w_commit) begin
                mode   <= r_pend_mode;
                box_x  <= r_pend_x;
                box_y  <= r_pend_y;
                colour <= r_pend_col;
            end
            case (r_state)
                CLEAN:   if (w_change) r_state <= DIRTY;
                DIRTY:   if (w_commit && !w_change) r_state <= CLEAN;
                default: r_state <= CLEAN;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_ctrl_sequencer.sv
// Directed bench for vga_ctrl_sequencer: expected commits are queued by the stimulus
// and checked by an independent monitor on every cfg_valid pulse.
`timescale 1ns/1ps
module tb_vga_ctrl_sequencer;
  logic       sysclk = 1'b0;
  logic       reset = 1'b1;
  logic       func_switch = 1'b0, East = 1'b0, West = 1'b0, North = 1'b0, South = 1'b0;
  logic       SW0 = 1'b0, SW1 = 1'b0, SW2 = 1'b0, SW3 = 1'b0;
  logic       frame_start = 1'b0;
  logic [1:0] mode;
  logic [9:0] box_x, box_y;
  logic [2:0] colour;
  logic       cfg_valid, dbg_dirty;

  logic [24:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  bit done = 0;

  vga_ctrl_sequencer #(.DEB_CYCLES(4), .STEP(8), .H_ACTIVE(640), .V_ACTIVE(480), .BOX(32)) dut (
    .sysclk(sysclk), .reset(reset), .func_switch(func_switch),
    .East(East), .West(West), .North(North), .South(South),
    .SW0(SW0), .SW1(SW1), .SW2(SW2), .SW3(SW3), .frame_start(frame_start),
    .mode(mode), .box_x(box_x), .box_y(box_y), .colour(colour),
    .cfg_valid(cfg_valid), .o_dbg_dirty(dbg_dirty)
  );

  // clock / reset
  always #10 sysclk = ~sysclk;

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // driver tasks; press mask bits: 0 func, 1 East, 2 West, 3 North, 4 South
  task automatic press(input logic [4:0] m);
    {South, North, West, East, func_switch} = m;
    tick(10);
    {South, North, West, East, func_switch} = 5'b0;
    tick(10);
  endtask

  task automatic set_sw(input int idx, input logic v);
    case (idx)
      0: SW0 = v;
      1: SW1 = v;
      2: SW2 = v;
      default: SW3 = v;
    endcase
    tick(12);
  endtask

  task automatic push_exp(input logic [1:0] m, input logic [9:0] x, input logic [9:0] y,
                          input logic [2:0] c);
    exp_q.push_back({m, x, y, c});
  endtask

  task automatic frame(input string name);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(4);
    check(name, exp_q.size(), 0);
  endtask

  // scoreboard monitor
  always @(negedge sysclk) begin
    if (cfg_valid) begin
      logic [24:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cfg_valid: got mode=%0d x=%0d y=%0d col=%b with none expected",
                 mode, box_x, box_y, colour);
      end else begin
        e = exp_q.pop_front();
        if ({mode, box_x, box_y, colour} !== e) begin
          errors++;
          $display("FAIL commit: got mode=%0d x=%0d y=%0d col=%b expected mode=%0d x=%0d y=%0d col=%b",
                   mode, box_x, box_y, colour, e[24:23], e[22:13], e[12:3], e[2:0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    if (!done) begin
      errors++;
      $display("FAIL timeout: bench did not complete within time budget");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    // 1. reset state
    tick(2);
    check("rst_mode", mode, 0);
    check("rst_box_x", box_x, 304);
    check("rst_box_y", box_y, 224);
    check("rst_colour", colour, 3'b111);
    check("rst_cfg_valid", cfg_valid, 0);
    reset = 1'b0;
    tick(2);
    check("rst_clean", dbg_dirty, 0);
    for (int i = 0; i < 3; i++) frame("idle_frame");

    // 2. glitch ignored, then mode sequence with wrap
    func_switch = 1'b1;
    tick(2);
    func_switch = 1'b0;
    tick(12);
    check("glitch_clean", dbg_dirty, 0);
    frame("glitch_frame");
    press(5'b00001);
    push_exp(2'd1, 10'd304, 10'd224, 3'b111);
    frame("mode1");
    for (int i = 0; i < 4; i++) begin
      logic [1:0] m;
      m = 2'(i + 2);
      press(5'b00001);
      push_exp(m, 10'd304, 10'd224, 3'b111);
      frame("mode_wrap");
    end
    check("mode_after_wrap", mode, 1);

    // 3. horizontal clamps
    for (int i = 0; i < 37; i++) press(5'b00010);
    push_exp(2'd1, 10'd600, 10'd224, 3'b111);
    frame("x600");
    press(5'b00010);
    push_exp(2'd1, 10'd608, 10'd224, 3'b111);
    frame("x608");
    press(5'b00010);
    check("east_clamp_clean", dbg_dirty, 0);
    frame("east_clamp_frame");
    for (int i = 0; i < 75; i++) press(5'b00100);
    push_exp(2'd1, 10'd8, 10'd224, 3'b111);
    frame("x8");
    press(5'b00100);
    push_exp(2'd1, 10'd0, 10'd224, 3'b111);
    frame("x0");
    press(5'b00100);
    check("west_clamp_clean", dbg_dirty, 0);
    frame("west_clamp_frame");

    // 4. opposing presses cancel; vertical moves; moves ignored outside mode 1
    press(5'b00110);
    check("ew_cancel_clean", dbg_dirty, 0);
    press(5'b11000);
    check("ns_cancel_clean", dbg_dirty, 0);
    frame("cancel_frame");
    press(5'b10000);
    push_exp(2'd1, 10'd0, 10'd232, 3'b111);
    frame("south");
    press(5'b01000);
    push_exp(2'd1, 10'd0, 10'd224, 3'b111);
    frame("north");
    for (int i = 0; i < 3; i++) press(5'b00001);
    push_exp(2'd0, 10'd0, 10'd224, 3'b111);
    frame("mode0");
    press(5'b01000);
    check("north_mode0_clean", dbg_dirty, 0);
    frame("north_mode0_frame");

    // 5. freeze
    set_sw(3, 1'b1);
    press(5'b00001);
    frame("freeze_frame1");
    frame("freeze_frame2");
    frame("freeze_frame3");
    check("freeze_mode", mode, 0);
    check("freeze_dirty", dbg_dirty, 1);
    set_sw(3, 1'b0);
    push_exp(2'd1, 10'd0, 10'd224, 3'b111);
    frame("unfreeze");

    // 6. reset while dirty, then a change coinciding with a commit
    set_sw(1, 1'b1);
    check("colour_dirty", dbg_dirty, 1);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    check("rst2_mode", mode, 0);
    check("rst2_box_x", box_x, 304);
    check("rst2_box_y", box_y, 224);
    check("rst2_colour", colour, 3'b111);
    check("rst2_clean", dbg_dirty, 0);
    frame("rst2_frame");
    tick(12);
    push_exp(2'd0, 10'd304, 10'd224, 3'b010);
    frame("colour010");
    press(5'b00001);
    push_exp(2'd1, 10'd304, 10'd224, 3'b010);
    SW0 = 1'b1;
    tick(6);
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    tick(4);
    check("coincide_commit", exp_q.size(), 0);
    check("coincide_redirty", dbg_dirty, 1);
    push_exp(2'd1, 10'd304, 10'd224, 3'b011);
    frame("coincide_next");
    tick(5);
    check("final_queue_empty", exp_q.size(), 0);

    done = 1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
